// File: rtl/unit_control_mc.sv
// Multicycle control sequencer for the lapido core: IF/ID/EX/MEM/WB with memory
// ready handshakes, fetch hold, data-memory timeout, illegal-type detection and retire count.
module unit_control_mc #(
    parameter int              OP_W     = 5,
    parameter int              TYPE_W   = 3,
    parameter int              CNT_W    = 16,
    parameter int              MEM_TO   = 8,
    parameter logic [OP_W-1:0] ALU_PASS = '0
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [TYPE_W-1:0] instr_type,
    input  logic [OP_W-1:0]   op,
    input  logic              cond_ok,
    input  logic              I_RDY,
    input  logic              D_RDY,
    input  logic              HOLD,
    output logic [2:0]        STATE_O,
    output logic [OP_W-1:0]   OP_ALU,
    output logic [2:0]        OP_TF,
    output logic              OP_SE,
    output logic              S_MXSE,
    output logic              W_MI,
    output logic              R_DM,
    output logic              W_DM,
    output logic              W_RB,
    output logic              W_RF,
    output logic [2:0]        S_RF,
    output logic [1:0]        S_MXRB,
    output logic              S_MXPC,
    output logic              W_PC,
    output logic              ILLEGAL,
    output logic              FAULT,
    output logic [CNT_W-1:0]  RETIRED
);

    typedef enum logic [2:0] {
        S_IF = 3'b000, S_ID = 3'b001, S_EX = 3'b011, S_MEM = 3'b010, S_WB = 3'b110
    } state_t;

    // Branch is encoded 0 so the reset value of the class register is harmless.
    typedef enum logic [2:0] {
        C_BR, C_ALU, C_LOAD, C_STORE, C_CONST, C_ILL
    } cls_t;

    localparam int TO_W = (MEM_TO > 1) ? $clog2(MEM_TO) : 1;

    state_t           state, nxt;
    cls_t             cls_q;
    logic [OP_W-1:0]  op_q;
    logic             cond_q;
    logic             fault_q;
    logic [TO_W-1:0]  to_cnt;
    logic [CNT_W-1:0] ret_q;
    logic             mem_to;

    // The type field is widened so any bits above the decoded three can be tested for zero.
    function automatic cls_t classify(input logic [TYPE_W-1:0] t);
        logic [31:0] tx;
        tx = 32'(t);
        if (tx[31:3] != '0) return C_ILL;
        case (tx[2:0])
            3'b001:  return C_ALU;
            3'b010:  return C_LOAD;
            3'b100:  return C_STORE;
            3'b110:  return C_CONST;
            3'b000:  return C_BR;
            default: return C_ILL;
        endcase
    endfunction

    function automatic logic [2:0] flag_mode(input logic [OP_W-1:0] o);
        if (o == OP_W'(5'b10011) || o == OP_W'(5'b11111)) return 3'b000;
        if (o == OP_W'(5'b10000))                          return 3'b001;
        if (o[4:3] == 2'b01)                               return 3'b011;
        if (o[4:3] == 2'b00)                               return 3'b100;
        return 3'b010;
    endfunction

    // D_RDY in the final allowed cycle still counts as success.
    assign mem_to  = (MEM_TO != 0) && (to_cnt == TO_W'(MEM_TO - 1)) && !D_RDY;
    assign STATE_O = state;
    assign RETIRED = ret_q;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) state <= S_IF;
        else     state <= nxt;
    end

    always_comb begin
        nxt = state;
        case (state)
            S_IF:    if (I_RDY && !HOLD) nxt = S_ID;
            S_ID:    nxt = S_EX;
            S_EX:    nxt = (cls_q == C_LOAD || cls_q == C_STORE) ? S_MEM : S_WB;
            S_MEM:   if (D_RDY || mem_to) nxt = S_WB;
            S_WB:    nxt = S_IF;
            default: nxt = S_IF;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cls_q   <= C_BR;
            op_q    <= '0;
            cond_q  <= 1'b0;
            fault_q <= 1'b0;
            to_cnt  <= '0;
            ret_q   <= '0;
        end else begin
            case (state)
                S_ID: begin
                    cls_q <= classify(instr_type);
                    op_q  <= op;
                end
                S_EX: begin
                    cond_q <= cond_ok;
                    to_cnt <= '0;
                end
                S_MEM: begin
                    if (mem_to)      fault_q <= 1'b1;
                    else if (!D_RDY) to_cnt  <= to_cnt + 1'b1;
                end
                S_WB: begin
                    ret_q   <= ret_q + 1'b1;
                    fault_q <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        OP_ALU  = '0;
        OP_TF   = 3'b000;
        OP_SE   = 1'b0;
        S_MXSE  = 1'b0;
        W_MI    = 1'b0;
        R_DM    = 1'b0;
        W_DM    = 1'b0;
        W_RB    = 1'b0;
        W_RF    = 1'b0;
        S_RF    = 3'b000;
        S_MXRB  = 2'b00;
        S_MXPC  = 1'b0;
        W_PC    = 1'b0;
        ILLEGAL = 1'b0;
        FAULT   = 1'b0;
        if (!RST) begin
            case (state)
                S_IF: W_MI = I_RDY && !HOLD;
                S_EX: begin
                    case (cls_q)
                        C_ALU: begin
                            OP_ALU = op_q;
                            OP_TF  = 3'b111;
                        end
                        C_LOAD, C_STORE, C_CONST: begin
                            OP_ALU = ALU_PASS;
                            OP_SE  = 1'b1;
                            S_MXSE = 1'b1;
                        end
                        C_BR:    OP_TF = op_q[2:0];
                        default: ;
                    endcase
                end
                S_MEM: begin
                    R_DM = (cls_q == C_LOAD);
                    W_DM = (cls_q == C_STORE);
                end
                S_WB: begin
                    W_PC  = 1'b1;
                    FAULT = fault_q;
                    case (cls_q)
                        C_ALU: begin
                            W_RB   = 1'b1;
                            S_MXRB = 2'b10;
                            W_RF   = 1'b1;
                            S_RF   = flag_mode(op_q);
                        end
                        C_LOAD: begin
                            W_RB   = !fault_q;
                            S_MXRB = fault_q ? 2'b00 : 2'b01;
                        end
                        C_CONST: begin
                            W_RB   = 1'b1;
                            S_MXRB = 2'b10;
                        end
                        C_BR:    S_MXPC  = cond_q;
                        C_ILL:   ILLEGAL = 1'b1;
                        default: ;
                    endcase
                end
                default: ;
            endcase
        end
    end

endmodule
